// File: rtl/merge_sorter_pass_scheduler.sv
// merge_sorter_pass_scheduler
// Sequences the merge phase of the merge sorter. After the chunk stage has
// written sorted runs of CHUNK_SIZE into bank 0, this block issues one merge
// command per run pair, pass by pass. Each pass doubles the run width and
// flips the source bank. When all passes are done it reports the bank that
// holds the sorted result.
//
// Ports:
//   clock_i, reset_ni    - clock, asynchronous active-low reset
//   start_i              - pulse; latches data_length_i
//   data_length_i        - element count, 0..MAX_SORT_LENGTH
//   chunks_ready_i       - pulse; chunk runs are present in bank 0
//   merge_valid_o/_ready_i - merge command handshake
//   merge_a_base_o       - run A start (run B follows run A; destination base = A base)
//   merge_a_length_o     - run A length
//   merge_b_length_o     - run B length (0 = copy run A only)
//   merge_src_bank_o     - bank read by the engine
//   merge_last_pass_o    - command belongs to the final pass
//   merge_done_i         - pulse; the engine finished the accepted command
//   busy_o, done_o       - activity flag and completion pulse
//   result_bank_o        - bank holding the sorted data, held until the next done
module merge_sorter_pass_scheduler #(
  parameter int unsigned MAX_SORT_LENGTH = 256,
  parameter int unsigned CHUNK_SIZE      = 8,
  localparam int unsigned LW = $clog2(MAX_SORT_LENGTH) + 1,
  localparam int unsigned AW = $clog2(MAX_SORT_LENGTH)
) (
  input  logic          clock_i,
  input  logic          reset_ni,
  input  logic          start_i,
  input  logic [LW-1:0] data_length_i,
  input  logic          chunks_ready_i,
  output logic          merge_valid_o,
  input  logic          merge_ready_i,
  output logic [AW-1:0] merge_a_base_o,
  output logic [LW-1:0] merge_a_length_o,
  output logic [LW-1:0] merge_b_length_o,
  output logic          merge_src_bank_o,
  output logic          merge_last_pass_o,
  input  logic          merge_done_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          result_bank_o
);

  // One extra bit so base + 2W never wraps at MAX_SORT_LENGTH.
  localparam int unsigned XW = LW + 1;
  localparam logic [XW-1:0] ChunkLen = XW'(CHUNK_SIZE);

  typedef enum logic [2:0] {
    StIdle, StWaitChunks, StIssue, StWaitMerge, StNext, StDone
  } state_e;

  state_e state_q, state_d;

  logic [XW-1:0] len_q, len_d;
  logic [XW-1:0] width_q, width_d;
  logic [XW-1:0] base_q, base_d;
  logic          bank_q, bank_d;

  logic [AW-1:0] a_base_q;
  logic [LW-1:0] a_len_q, b_len_q;
  logic          src_bank_q, last_pass_q, result_bank_q;

  logic [XW-1:0] width2_q, next_base;
  logic [XW-1:0] rem_a, end_a, rem_b, a_len_n, b_len_n;
  logic          last_n;
  logic          enter_issue, enter_done;
  logic          unused_bits;

  assign width2_q  = width_q << 1;
  assign next_base = base_q + width2_q;

  // State register
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= StIdle;
    else           state_q <= state_d;
  end

  // Next-state and pass bookkeeping
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    width_d = width_q;
    base_d  = base_q;
    bank_d  = bank_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StWaitChunks;
          len_d   = XW'(data_length_i);
          width_d = ChunkLen;
          base_d  = '0;
          bank_d  = 1'b0;
        end
      end
      StWaitChunks: begin
        if (chunks_ready_i) state_d = (len_q > ChunkLen) ? StIssue : StDone;
      end
      StIssue: begin
        if (merge_ready_i) state_d = StWaitMerge;
      end
      StWaitMerge: begin
        if (merge_done_i) state_d = StNext;
      end
      StNext: begin
        if (next_base < len_q) begin
          base_d  = next_base;
          state_d = StIssue;
        end else begin
          // Pass complete: runs are twice as wide and now live in the other bank.
          bank_d  = ~bank_q;
          width_d = width2_q;
          base_d  = '0;
          state_d = (width2_q < len_q) ? StIssue : StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Command fields derived from the values the FSM is about to issue with.
  always_comb begin
    rem_a   = len_d - base_d;
    a_len_n = (width_d < rem_a) ? width_d : rem_a;
    end_a   = base_d + width_d;
    rem_b   = len_d - end_a;
    if (len_d > end_a) b_len_n = (width_d < rem_b) ? width_d : rem_b;
    else               b_len_n = '0;
    last_n  = ((width_d << 1) >= len_d);
  end

  assign enter_issue = (state_d == StIssue) && (state_q != StIssue);
  assign enter_done  = (state_d == StDone) && (state_q != StDone);

  // Lengths never exceed MAX_SORT_LENGTH and bases stay below it.
  assign unused_bits = ^{a_len_n[XW-1], b_len_n[XW-1], base_d[XW-1:AW]};

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      len_q         <= '0;
      width_q       <= '0;
      base_q        <= '0;
      bank_q        <= 1'b0;
      a_base_q      <= '0;
      a_len_q       <= '0;
      b_len_q       <= '0;
      src_bank_q    <= 1'b0;
      last_pass_q   <= 1'b0;
      result_bank_q <= 1'b0;
    end else begin
      len_q   <= len_d;
      width_q <= width_d;
      base_q  <= base_d;
      bank_q  <= bank_d;
      if (enter_issue) begin
        a_base_q    <= base_d[AW-1:0];
        a_len_q     <= a_len_n[LW-1:0];
        b_len_q     <= b_len_n[LW-1:0];
        src_bank_q  <= bank_d;
        last_pass_q <= last_n;
      end
      if (enter_done) result_bank_q <= bank_d;
    end
  end

  // Outputs
  always_comb begin
    merge_valid_o     = (state_q == StIssue);
    busy_o            = (state_q != StIdle);
    done_o            = (state_q == StDone);
    merge_a_base_o    = a_base_q;
    merge_a_length_o  = a_len_q;
    merge_b_length_o  = b_len_q;
    merge_src_bank_o  = src_bank_q;
    merge_last_pass_o = last_pass_q;
    result_bank_o     = result_bank_q;
  end

endmodule
